arm_fetch: RTL and testbench
============================

# arm_fetch

Instruction fetch stage that drives the read side (port 1) of `arm_memory` and feeds decode. It holds the program counter and issues one word read per cycle while buffer space is available. Returned words are captured with their PC and abort flag into a small prefetch FIFO, and decode drains that FIFO through a valid/ready handshake. Branch redirects from execute flush the FIFO and discard any read still in flight.

## Interface
- `RESET_PC`, 32'h00000000, PC loaded on reset; bits [1:0] must be 0.
- `DEPTH`, 4, prefetch FIFO entries; power of two, 2..16.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `mem_addr`  out  32  read address to `arm_memory` addr1; always word aligned.
- `mem_data`  in  32  `arm_memory` data_out1; valid the cycle after the address was presented.
- `mem_excpt`  in  1  `arm_memory` excpt; qualifies `mem_data` in the same cycle.
- `branch_valid`  in  1  redirect request, single-cycle pulse.
- `branch_target`  in  32  redirect PC; bits [1:0] are ignored and forced to 0.
- `inst_valid`  out  1  FIFO head is valid.
- `inst`  out  32  instruction word at the FIFO head.
- `inst_pc`  out  32  address of `inst`.
- `inst_abort`  out  1  head fetch faulted; `inst` is 0.
- `inst_ready`  in  1  decode accepts the head this cycle.

## Operation
- **State:**
  - `pc` (32b).
  - `inflight` (1b) with `inflight_pc`.
  - FIFO storing {abort, pc, word}, with read/write pointers and count.
  - Mode register: `RUN` or `HALT`.
- **Reset** (`rst` low, asynchronous):
  - `pc`=RESET_PC, FIFO empty, `inflight`=0, mode=`RUN`.
  - Outputs: `mem_addr`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, `inst_abort`=0.
- **Address:** `mem_addr` = `pc` at all times.
- **Issue:** occurs when mode=`RUN` and count + `inflight` < DEPTH, evaluated after this cycle's pop.
  - Registers `inflight`=1 and `inflight_pc`=`pc`.
  - Advances `pc` by 4; 32-bit wrap from FFFFFFFC to 00000000 is silent.
  - No issue means `pc` holds, and the data returned next cycle is ignored.
- **Capture:** in a cycle with `inflight`=1, {`mem_excpt`, `inflight_pc`, `mem_excpt`?0:`mem_data`} is pushed into the FIFO.
  - Capture on a clean word: `inflight` clears unless a new issue occurs in the same cycle.
  - Capture with `mem_excpt`=1: the faulted entry is pushed as above, `inflight` clears, mode goes to `HALT`, and `pc` is left at the faulting address + 4. No further issue happens until a branch.
- **Pop:** occurs when `inst_valid` and `inst_ready` are both 1. Pop and push may happen in the same cycle; count stays unchanged.
- **Branch** (`branch_valid`=1):
  - FIFO is flushed, `inflight` clears, and any response arriving this cycle is dropped.
  - `pc` becomes the aligned `branch_target`, and mode goes to `RUN`.
  - Branch has priority over issue, capture, pop and halt in that cycle.
  - The first issue at the target happens in the next cycle.
- **Empty:** `inst_valid`=0; `inst`, `inst_pc` and `inst_abort` hold their last values and must not be used.
- **Full:** issue is blocked by the credit rule, so the FIFO never overflows and no response is ever lost.

## Timing
- Issue in cycle N → the word is captured at the end of N+1 → it is at the FIFO head (`inst_valid`) in cycle N+2.
- From reset release: the first edge issues RESET_PC, and `inst_valid` rises after the second edge.
- Steady-state throughput is 1 instruction per cycle when `inst_ready` is held at 1.
- Branch asserted in cycle B:
  - `inst_valid`=0 in B+1.
  - Target issued in B+1.
  - Target instruction is at the head in B+3, so the redirect penalty is 2 bubbles.
- Stall: with `inst_ready`=0, the FIFO fills to DEPTH, at which point issue stops.
  - After the first pop, one issue resumes in that same cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for `clk`. Nothing in flight survives.

## Test plan
- **Reset and stream.** Memory holds word k at address 4k; hold `inst_ready`=1 from reset.
  - First `inst_valid` appears 2 cycles after release, with `inst_pc`=0 and `inst`=0.
  - Subsequent cycles show `inst_pc`=4, 8, 12, … and `inst`=1, 2, 3, … back-to-back with no bubbles.
- **Backpressure.** Hold `inst_ready`=0 for 10 cycles.
  - Count saturates at 4 and `mem_addr` freezes at 0x10.
  - After release, the heads are 0x0, 0x4, 0x8, 0xC, 0x10 in order, with no duplicates or gaps.
- **Branch.** Stream from 0, then pulse `branch_valid` with `branch_target`=0x0000010F.
  - The next valid head has `inst_pc`=0x10C after exactly 2 bubbles.
  - No word from the old stream appears after the branch cycle.
- **Fault.** `arm_memory` asserts excpt on the read of 0x8.
  - Heads are 0x0, 0x4, then 0x8 with `inst_abort`=1 and `inst`=0.
  - `inst_valid` then stays 0 and `mem_addr` stays at 0xC for 20 cycles.
  - A branch to 0x0 resumes fetching normally.
- **Simultaneous events.** Branch in the same cycle as a pop of a full FIFO and a capture: the FIFO ends empty and the next head is the target.
  - Separately, assert a branch in the same cycle a fault returns: no abort entry is ever visible.
- **Async reset mid-stream.** Drop `rst` between clock edges while the FIFO is full: `inst_valid`=0 and `mem_addr`=RESET_PC immediately. After release, streaming restarts from RESET_PC.

Source files
------------

// File: rtl/arm_fetch.sv
// arm_fetch: instruction fetch stage.
// Holds the program counter and issues one word read per cycle to the
// arm_memory read port while prefetch credit is available. Returned words
// are queued with their PC and abort flag, and decode drains the queue
// through a valid/ready handshake. A branch redirect flushes the queue and
// drops any read that is still in flight.
module arm_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_data,
  input  logic        mem_excpt,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_abort,
  input  logic        inst_ready
);

  // Pointer width, and count width wide enough to hold DEPTH itself.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] MODE_RUN  = 1'b0;
  localparam logic [0:0] MODE_HALT = 1'b1;

  // Architectural fetch state.
  logic [31:0] pc;
  logic [0:0]  mode;
  logic        inflight;
  logic [31:0] inflight_pc;

  // Prefetch queue storage and bookkeeping.
  logic [31:0] fifo_word  [DEPTH];
  logic [31:0] fifo_pc    [DEPTH];
  logic        fifo_abort [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // Registered head of the queue; holds its last value while empty.
  logic [31:0] head_word;
  logic [31:0] head_pc;
  logic        head_abort;

  // Per-cycle decisions.
  logic          pop;
  logic          push;
  logic          fault;
  logic          issue;
  logic [31:0]   push_word;
  logic          push_abort;
  logic [CW-1:0] cnt_after_pop;
  logic [CW-1:0] credit_sum;
  logic [PW-1:0] rd_next;

  assign mem_addr   = pc;
  assign inst_valid = (count != '0);
  assign inst       = head_word;
  assign inst_pc    = head_pc;
  assign inst_abort = head_abort;

  // Decide pop, capture and issue for this cycle. Credit is checked after
  // this cycle's pop; a capture simply turns the in-flight slot into a
  // queue entry, so it does not change the count+inflight total. A faulting
  // capture suppresses issue so the PC stays at fault address + 4.
  always_comb begin
    pop           = inst_valid && inst_ready;
    push          = inflight;
    fault         = inflight && mem_excpt;
    push_abort    = mem_excpt;
    push_word     = mem_excpt ? 32'h0000_0000 : mem_data;
    cnt_after_pop = count - CW'(pop);
    credit_sum    = cnt_after_pop + CW'(inflight);
    rd_next       = rd_ptr + PW'(pop);
    issue         = !branch_valid && (mode == MODE_RUN) && !fault &&
                    (credit_sum < CW'(DEPTH));
  end

  // PC, run/halt mode and the single outstanding read; branch wins over all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      mode        <= MODE_RUN;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0000_0000;
    end else if (branch_valid) begin
      pc       <= branch_target & ~32'h0000_0003;
      mode     <= MODE_RUN;
      inflight <= 1'b0;
    end else begin
      if (fault) begin
        mode <= MODE_HALT;
      end
      if (issue) begin
        inflight    <= 1'b1;
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // Queue pointers and occupancy; a branch empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      count <= cnt_after_pop + CW'(push);
    end
  end

  // Queue storage; entries are only observed after being written.
  always_ff @(posedge clk) begin
    if (push && !branch_valid) begin
      fifo_word[wr_ptr]  <= push_word;
      fifo_pc[wr_ptr]    <= inflight_pc;
      fifo_abort[wr_ptr] <= push_abort;
    end
  end

  // Head register: load the entry that will be at the head after this edge,
  // bypassing the captured word when it lands in an otherwise empty queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_word  <= 32'h0000_0000;
      head_pc    <= 32'h0000_0000;
      head_abort <= 1'b0;
    end else if (!branch_valid) begin
      if (cnt_after_pop != '0) begin
        head_word  <= fifo_word[rd_next];
        head_pc    <= fifo_pc[rd_next];
        head_abort <= fifo_abort[rd_next];
      end else if (push) begin
        head_word  <= push_word;
        head_pc    <= inflight_pc;
        head_abort <= push_abort;
      end
    end
  end

endmodule

// File: tb/tb_arm_fetch.sv
// tb_arm_fetch: directed self-checking bench for arm_fetch with a simple
// one-cycle-latency memory model (word k lives at address 4k).
module tb_arm_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        mem_excpt = 1'b0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_abort;
  logic        inst_ready = 1'b0;

  logic        fault_en = 1'b0;
  logic [31:0] fault_addr = 32'h0;

  int checks = 0;
  int errors = 0;

  arm_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_excpt     (mem_excpt),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_abort    (inst_abort),
    .inst_ready    (inst_ready)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Memory model: registered read, data valid the cycle after the address.
  always @(posedge clk) begin
    mem_data  <= {2'b00, mem_addr[31:2]};
    mem_excpt <= fault_en && (mem_addr == fault_addr);
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n clock edges and settle just after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive the decode/branch inputs.
  task automatic applyStimulus(input logic ready, input logic bv,
                               input logic [31:0] bt);
    inst_ready    = ready;
    branch_valid  = bv;
    branch_target = bt;
  endtask

  // Hold reset across one edge and release it away from the edge.
  task automatic applyReset(input logic ready);
    rst = 1'b0;
    applyStimulus(ready, 1'b0, 32'h0);
    step(1);
    rst = 1'b1;
  endtask

  // Check a valid head entry.
  task automatic checkHead(input string tag, input logic [31:0] pc,
                           input logic [31:0] word, input logic abort);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'h1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_inst"}, inst, word);
    checkOutput({tag, "_abort"}, 32'(inst_abort), 32'(abort));
  endtask

  initial begin
    // Reset and stream.
    applyStimulus(1'b1, 1'b0, 32'h0);
    step(1);
    checkOutput("rst_valid", 32'(inst_valid), 32'h0);
    checkOutput("rst_addr", mem_addr, 32'h0);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_pc", inst_pc, 32'h0);
    checkOutput("rst_abort", 32'(inst_abort), 32'h0);
    rst = 1'b1;
    step(1);
    checkOutput("first_edge_valid", 32'(inst_valid), 32'h0);
    checkOutput("first_edge_addr", mem_addr, 32'h4);
    step(1);
    checkHead("stream0", 32'h0, 32'h0, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step(1);
      checkHead("stream", 32'(4 * k), 32'(k), 1'b0);
    end

    // Backpressure: queue fills to four entries and PC freezes at 0x10.
    applyReset(1'b0);
    step(10);
    checkOutput("bp_addr", mem_addr, 32'h10);
    checkHead("bp_head0", 32'h0, 32'h0, 1'b0);
    step(1);
    checkOutput("bp_addr_frozen", mem_addr, 32'h10);
    inst_ready = 1'b1;
    step(1);
    checkOutput("bp_resume_addr", mem_addr, 32'h14);
    checkHead("bp_head1", 32'h4, 32'h1, 1'b0);
    step(1);
    checkHead("bp_head2", 32'h8, 32'h2, 1'b0);
    step(1);
    checkHead("bp_head3", 32'hC, 32'h3, 1'b0);
    step(1);
    checkHead("bp_head4", 32'h10, 32'h4, 1'b0);
    step(1);
    checkHead("bp_head5", 32'h14, 32'h5, 1'b0);

    // Branch to an unaligned target: two bubbles then 0x10C.
    applyReset(1'b1);
    step(6);
    checkHead("br_pre", 32'h10, 32'h4, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_010F);
    step(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("br_bubble1_valid", 32'(inst_valid), 32'h0);
    checkOutput("br_bubble1_addr", mem_addr, 32'h10C);
    step(1);
    checkOutput("br_bubble2_valid", 32'(inst_valid), 32'h0);
    checkOutput("br_bubble2_addr", mem_addr, 32'h110);
    step(1);
    checkHead("br_target", 32'h10C, 32'h43, 1'b0);
    step(1);
    checkHead("br_next", 32'h110, 32'h44, 1'b0);

    // Fault on the read of 0x8: abort entry, then halt at 0xC.
    fault_en   = 1'b1;
    fault_addr = 32'h8;
    applyReset(1'b1);
    step(2);
    checkHead("flt_h0", 32'h0, 32'h0, 1'b0);
    step(1);
    checkHead("flt_h1", 32'h4, 32'h1, 1'b0);
    step(1);
    checkHead("flt_abort", 32'h8, 32'h0, 1'b1);
    checkOutput("flt_addr", mem_addr, 32'hC);
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput("flt_halt_valid", 32'(inst_valid), 32'h0);
      checkOutput("flt_halt_addr", mem_addr, 32'hC);
    end
    fault_en = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h0);
    step(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("flt_br_valid", 32'(inst_valid), 32'h0);
    checkOutput("flt_br_addr", mem_addr, 32'h0);
    step(2);
    checkHead("flt_resume0", 32'h0, 32'h0, 1'b0);
    step(1);
    checkHead("flt_resume1", 32'h4, 32'h1, 1'b0);

    // Branch together with pop and capture just after a full queue drains one.
    applyReset(1'b0);
    step(10);
    checkHead("sim_full_head", 32'h0, 32'h0, 1'b0);
    inst_ready = 1'b1;
    step(1);
    checkOutput("sim_issue_addr", mem_addr, 32'h14);
    applyStimulus(1'b1, 1'b1, 32'h200);
    step(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("sim_flush_valid", 32'(inst_valid), 32'h0);
    checkOutput("sim_flush_addr", mem_addr, 32'h200);
    step(1);
    checkOutput("sim_bubble_valid", 32'(inst_valid), 32'h0);
    step(1);
    checkHead("sim_target", 32'h200, 32'h80, 1'b0);
    step(1);
    checkHead("sim_next", 32'h204, 32'h81, 1'b0);

    // Branch in the same cycle a fault returns: no abort entry is visible.
    fault_en   = 1'b1;
    fault_addr = 32'h8;
    applyReset(1'b1);
    step(3);
    checkHead("bf_h1", 32'h4, 32'h1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    step(1);
    applyStimulus(1'b1, 1'b0, 32'h0);
    checkOutput("bf_valid1", 32'(inst_valid), 32'h0);
    step(1);
    checkOutput("bf_valid2", 32'(inst_valid), 32'h0);
    step(1);
    checkHead("bf_target", 32'h40, 32'h10, 1'b0);
    fault_en = 1'b0;

    // Asynchronous reset between edges while the queue is full.
    applyReset(1'b0);
    step(8);
    checkOutput("ar_pre_valid", 32'(inst_valid), 32'h1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("ar_valid", 32'(inst_valid), 32'h0);
    checkOutput("ar_addr", mem_addr, 32'h0);
    checkOutput("ar_inst", inst, 32'h0);
    step(1);
    checkOutput("ar_held_valid", 32'(inst_valid), 32'h0);
    rst = 1'b1;
    inst_ready = 1'b1;
    step(1);
    checkOutput("ar_edge1_valid", 32'(inst_valid), 32'h0);
    step(1);
    checkHead("ar_h0", 32'h0, 32'h0, 1'b0);
    step(1);
    checkHead("ar_h1", 32'h4, 32'h1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
